// File: rtl/ks_poly_string_pkg.sv
// Shared types and helpers for the polyphonic Karplus-Strong string engine.
package ks_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_MIX  = 2'd2
  } ks_state_e;

  // Three-level excitation derived from the external noise bits.
  typedef enum logic [1:0] {
    NOISE_ZERO = 2'd0,
    NOISE_NEG  = 2'd1,
    NOISE_POS  = 2'd2
  } ks_noise_e;

  function automatic ks_noise_e noise_level(input logic [1:0] prbs);
    ks_noise_e lvl;
    lvl = NOISE_ZERO;
    if (prbs[1]) lvl = prbs[0] ? NOISE_POS : NOISE_NEG;
    return lvl;
  endfunction

  // Clamp a wide signed value into a dw-bit signed range.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int unsigned dw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] r;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (dw - 1));
    r  = v;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/ks_voice_dp.sv
// Per-voice loop arithmetic: two-tap average, noise, rounding, optional decay, saturation.
// Optional decay term is enabled by defining KS_POLY_DECAY_EN.
module ks_voice_dp
  import ks_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FRAC_BITS   = 4,
  parameter int unsigned DECAY_SHIFT = 6
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] x_prev,
  input  logic                         burst_active,
  input  logic [1:0]                   prbs,
  output logic signed [DATA_WIDTH-1:0] y_c
);

`ifdef KS_POLY_DECAY_EN
  localparam bit DECAY_ON = 1'b1;
`else
  localparam bit DECAY_ON = 1'b0;
`endif

  localparam logic signed [31:0] S_MAX = (32'sd1 <<< (DATA_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] S_MIN = -(32'sd1 <<< (DATA_WIDTH - 1));
  localparam logic signed [31:0] RND   = 32'sd1 <<< (FRAC_BITS - 1);

  logic signed [31:0] avg_c;
  logic signed [31:0] noise_c;
  logic signed [31:0] acc_c;
  logic signed [31:0] sat_c;

  // Fixed-point update; the sum is rescaled to integer samples before clamping.
  always_comb begin
    avg_c   = ((32'(x) + 32'(x_prev)) <<< FRAC_BITS) >>> 1;
    noise_c = '0;
    if (burst_active) begin
      case (noise_level(prbs))
        NOISE_NEG: noise_c = S_MIN <<< FRAC_BITS;
        NOISE_POS: noise_c = S_MAX <<< FRAC_BITS;
        default:   noise_c = '0;
      endcase
    end
    acc_c = avg_c + noise_c + RND;
    if (DECAY_ON) acc_c = acc_c - (acc_c >>> DECAY_SHIFT);
    sat_c = saturate(acc_c >>> FRAC_BITS, DATA_WIDTH);
    y_c   = DATA_WIDTH'(sat_c);
  end

endmodule

// File: rtl/ks_poly_string.sv
// Time-multiplexed Karplus-Strong string bank: one voice per cycle, summed mix per tick.
// Build option KS_POLY_DECAY_EN adds per-update decay inside ks_voice_dp.
module ks_poly_string
  import ks_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned MAX_LENGTH  = 64,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FRAC_BITS   = 4,
  parameter int unsigned DECAY_SHIFT = 6
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            sample_tick_i,
  input  logic                                            freeze_i,
  input  logic                                            pluck_valid_i,
  output logic                                            pluck_ready_o,
  input  logic [$clog2(NUM_VOICES)-1:0]                   pluck_voice_i,
  input  logic [$clog2(MAX_LENGTH):0]                     pluck_period_i,
  input  logic [1:0]                                      prbs_data_i,
  output logic signed [DATA_WIDTH+$clog2(NUM_VOICES)-1:0] mix_o,
  output logic                                            mix_valid_o,
  output logic [NUM_VOICES-1:0]                           voice_active_o,
  output logic                                            overrun_o
);

  localparam int unsigned VOICE_W = $clog2(NUM_VOICES);
  localparam int unsigned PTR_W   = $clog2(MAX_LENGTH);
  localparam int unsigned PER_W   = PTR_W + 1;
  localparam int unsigned MIX_W   = DATA_WIDTH + VOICE_W;
  localparam int unsigned DEPTH   = NUM_VOICES * MAX_LENGTH;
  localparam int unsigned ADDR_W  = $clog2(DEPTH);

  ks_state_e state_q, state_d;
  logic [VOICE_W-1:0] idx_q, idx_d;

  logic tick_accept_c, overrun_c, proc_en_c, mix_load_c, pluck_fire_c, commit_c;

  logic [PTR_W-1:0]             ptr_q    [NUM_VOICES];
  logic signed [DATA_WIDTH-1:0] xprev_q  [NUM_VOICES];
  logic [PER_W-1:0]             period_q [NUM_VOICES];
  logic [PER_W-1:0]             burst_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0]        lap_q;
  logic signed [DATA_WIDTH-1:0] mem      [DEPTH];
  logic signed [MIX_W-1:0]      acc_q;

  logic [PTR_W-1:0]             ptr_cur_c;
  logic [ADDR_W-1:0]            addr_c;
  logic signed [DATA_WIDTH-1:0] x_c, y_c, contrib_c;
  logic [PER_W-1:0]             period_clamp_c;
  logic                         wrap_c;

  // Round sequencing: IDLE waits for a tick, PROC walks the voices, MIX publishes.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tick_accept_c = 1'b0;
    overrun_c     = 1'b0;
    proc_en_c     = 1'b0;
    mix_load_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick_i) begin
          tick_accept_c = 1'b1;
          idx_d         = '0;
          state_d       = ST_PROC;
        end
      end
      ST_PROC: begin
        overrun_c = sample_tick_i;
        proc_en_c = 1'b1;
        if (idx_q == VOICE_W'(NUM_VOICES - 1)) state_d = ST_MIX;
        else idx_d = VOICE_W'(idx_q + 1'b1);
      end
      ST_MIX: begin
        overrun_c  = sample_tick_i;
        mix_load_c = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ring access for the voice in flight; unwritten laps read as silence.
  always_comb begin
    pluck_fire_c = pluck_valid_i & pluck_ready_o;
    ptr_cur_c    = ptr_q[idx_q];
    addr_c       = ADDR_W'(idx_q) * ADDR_W'(MAX_LENGTH) + ADDR_W'(ptr_cur_c);
    x_c          = lap_q[idx_q] ? mem[addr_c] : '0;
    contrib_c    = freeze_i ? xprev_q[idx_q] : y_c;
    commit_c     = proc_en_c & ~freeze_i;
    wrap_c       = (PER_W'(ptr_cur_c) + PER_W'(1)) >= period_q[idx_q];
    if (pluck_period_i < PER_W'(2))               period_clamp_c = PER_W'(2);
    else if (pluck_period_i > PER_W'(MAX_LENGTH)) period_clamp_c = PER_W'(MAX_LENGTH);
    else                                          period_clamp_c = pluck_period_i;
  end

  ks_voice_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_voice_dp (
    .x           (x_c),
    .x_prev      (xprev_q[idx_q]),
    .burst_active(voice_active_o[idx_q]),
    .prbs        (prbs_data_i),
    .y_c         (y_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      pluck_ready_o  <= 1'b1;
      mix_o          <= '0;
      mix_valid_o    <= 1'b0;
      overrun_o      <= 1'b0;
      acc_q          <= '0;
      voice_active_o <= '0;
      lap_q          <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        ptr_q[v]    <= '0;
        xprev_q[v]  <= '0;
        period_q[v] <= PER_W'(2);
        burst_q[v]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pluck_ready_o <= (state_d == ST_IDLE);
      mix_valid_o   <= mix_load_c;
      overrun_o     <= overrun_c;
      if (tick_accept_c) acc_q <= '0;
      if (proc_en_c)     acc_q <= acc_q + MIX_W'(contrib_c);
      if (mix_load_c)    mix_o <= acc_q;
      if (commit_c) begin
        xprev_q[idx_q] <= y_c;
        if (wrap_c) begin
          ptr_q[idx_q] <= '0;
          lap_q[idx_q] <= 1'b1;
        end else begin
          ptr_q[idx_q] <= PTR_W'(ptr_cur_c + 1'b1);
        end
        if (burst_q[idx_q] != '0) begin
          burst_q[idx_q] <= PER_W'(burst_q[idx_q] - 1'b1);
          if (burst_q[idx_q] == PER_W'(1)) voice_active_o[idx_q] <= 1'b0;
        end
      end
      // A pluck restarts the voice: fresh lap, new length, new burst.
      if (pluck_fire_c) begin
        period_q[pluck_voice_i]       <= period_clamp_c;
        burst_q[pluck_voice_i]        <= period_clamp_c;
        ptr_q[pluck_voice_i]          <= '0;
        lap_q[pluck_voice_i]          <= 1'b0;
        voice_active_o[pluck_voice_i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit_c && !rst_i) mem[addr_c] <= y_c;
  end

endmodule

// File: tb/tb_ks_poly_string.sv
// Randomized self-checking bench for ks_poly_string against an integer string model.
module tb_ks_poly_string;

  localparam int NV = 4;
  localparam int ML = 64;
  localparam int DW = 8;
  localparam int FB = 4;
  localparam int DS = 6;
  localparam int SMAX = (1 << (DW - 1)) - 1;
  localparam int SMIN = -(1 << (DW - 1));

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              sample_tick_i;
  logic              freeze_i;
  logic              pluck_valid_i;
  logic              pluck_ready_o;
  logic [1:0]        pluck_voice_i;
  logic [6:0]        pluck_period_i;
  logic [1:0]        prbs_data_i;
  logic signed [9:0] mix_o;
  logic              mix_valid_o;
  logic [NV-1:0]     voice_active_o;
  logic              overrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  int m_ring [NV][ML];
  int m_ptr  [NV];
  int m_prev [NV];
  int m_per  [NV];
  int m_burst[NV];

  ks_poly_string #(
    .NUM_VOICES(NV), .MAX_LENGTH(ML), .DATA_WIDTH(DW), .FRAC_BITS(FB), .DECAY_SHIFT(DS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sample_tick_i(sample_tick_i), .freeze_i(freeze_i),
    .pluck_valid_i(pluck_valid_i), .pluck_ready_o(pluck_ready_o),
    .pluck_voice_i(pluck_voice_i), .pluck_period_i(pluck_period_i),
    .prbs_data_i(prbs_data_i), .mix_o(mix_o), .mix_valid_o(mix_valid_o),
    .voice_active_o(voice_active_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_ptr[v] = 0; m_prev[v] = 0; m_per[v] = 2; m_burst[v] = 0;
      for (int i = 0; i < ML; i++) m_ring[v][i] = 0;
    end
  endtask

  function automatic int clamp_period(input int p);
    if (p < 2) return 2;
    if (p > ML) return ML;
    return p;
  endfunction

  task automatic model_pluck(input int v, input int p);
    m_per[v] = clamp_period(p);
    m_ptr[v] = 0;
    m_burst[v] = m_per[v];
    for (int i = 0; i < ML; i++) m_ring[v][i] = 0;
  endtask

  function automatic int voice_y(input int x, input int xp, input int noise);
    int t;
    t = (x + xp) * (1 << (FB - 1)) + noise * (1 << FB) + (1 << (FB - 1));
`ifdef KS_POLY_DECAY_EN
    t = t - (t >>> DS);
`endif
    t = t >>> FB;
    if (t > SMAX) t = SMAX;
    if (t < SMIN) t = SMIN;
    return t;
  endfunction

  task automatic model_round(input bit frz, input logic [1:0] pr, output int mix);
    int x, y, nz;
    mix = 0;
    for (int v = 0; v < NV; v++) begin
      if (frz) begin
        mix += m_prev[v];
      end else begin
        x  = m_ring[v][m_ptr[v]];
        nz = 0;
        if (m_burst[v] > 0 && pr[1]) nz = pr[0] ? SMAX : SMIN;
        y = voice_y(x, m_prev[v], nz);
        m_ring[v][m_ptr[v]] = y;
        m_prev[v] = y;
        m_ptr[v]  = (m_ptr[v] + 1) % m_per[v];
        if (m_burst[v] > 0) m_burst[v]--;
        mix += y;
      end
    end
  endtask

  function automatic logic [NV-1:0] model_active();
    logic [NV-1:0] a;
    for (int v = 0; v < NV; v++) a[v] = (m_burst[v] > 0);
    return a;
  endfunction

  // One full tick round, optionally with a pluck in the same IDLE cycle.
  task automatic do_round(input bit frz, input bit pl, input int pv, input int pp,
                          input int prbs_sel, output int got_mix);
    int exp_mix, lat, ov;
    logic [1:0] pr;
    @(negedge clk_i);
    check("ready_idle", pluck_ready_o, 1);
    pr = (prbs_sel < 0) ? 2'($urandom) : 2'(prbs_sel);
    prbs_data_i = pr;
    freeze_i    = frz;
    if (pl) begin
      pluck_valid_i  = 1'b1;
      pluck_voice_i  = 2'(pv);
      pluck_period_i = 7'(pp);
      model_pluck(pv, pp);
    end
    sample_tick_i = 1'b1;
    model_round(frz, pr, exp_mix);
    @(posedge clk_i); #1;
    sample_tick_i = 1'b0;
    pluck_valid_i = 1'b0;
    check("ready_busy", pluck_ready_o, 0);
    lat = 0; ov = 0;
    while (!mix_valid_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
      ov += int'(overrun_o);
    end
    check("latency", lat, NV + 1);
    check("overrun", ov, 0);
    check("mix", $signed(mix_o), exp_mix);
    check("active", voice_active_o, model_active());
    got_mix = $signed(mix_o);
  endtask

  initial begin
    int m, prev_m, m0, cnt, exp_mix, ov, mv, got;
    int per_in[3];
    int per_exp[3];
    logic [1:0] pr;
    per_in  = '{0, 1, 200};
    per_exp = '{2, 2, 64};

    rst_i = 1'b1; sample_tick_i = 1'b0; freeze_i = 1'b0; pluck_valid_i = 1'b0;
    pluck_voice_i = '0; pluck_period_i = '0; prbs_data_i = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_mix", $signed(mix_o), 0);
    check("rst_mix_valid", mix_valid_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_active", voice_active_o, 0);
    check("rst_ready", pluck_ready_o, 1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Idle round after reset.
    do_round(0, 0, 0, 0, -1, m);
    check("tick_mix0", m, 0);

    // Pluck voice 2 with the positive noise level held: saturated burst then DC.
    do_round(0, 1, 2, 8, 3, m);
`ifndef KS_POLY_DECAY_EN
    check("sat127", m, 127);
`endif
    for (int k = 1; k < 8; k++) begin
      do_round(0, 0, 0, 0, 3, m);
      check("sat127", m, 127);
    end
    check("burst_done", voice_active_o[2], 0);
    prev_m = m;
    for (int k = 0; k < 6; k++) begin
      do_round(0, 0, 0, 0, 3, m);
`ifdef KS_POLY_DECAY_EN
      check("decay_drop", int'(m < prev_m), 1);
`else
      check("dc_hold", m, 127);
`endif
      prev_m = m;
    end

    // Second tick two cycles after the first: one overrun, one mix.
    @(negedge clk_i);
    pr = 2'($urandom);
    prbs_data_i = pr; freeze_i = 1'b0; sample_tick_i = 1'b1;
    model_round(0, pr, exp_mix);
    @(posedge clk_i); #1 sample_tick_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i); sample_tick_i = 1'b1;
    @(posedge clk_i); #1 sample_tick_i = 1'b0;
    ov = int'(overrun_o); mv = 0; got = 0;
    repeat (12) begin
      @(posedge clk_i); #1;
      ov += int'(overrun_o);
      if (mix_valid_o) begin mv++; got = $signed(mix_o); end
    end
    check("ovr_pulses", ov, 1);
    check("ovr_mix_valid", mv, 1);
    check("ovr_mix", got, exp_mix);

    // Period clamping observed through burst length, then a few laps past wrap.
    for (int i = 0; i < 3; i++) begin
      do_round(0, 1, 0, per_in[i], -1, m);
      cnt = 1;
      while (voice_active_o[0] && cnt < 100) begin
        do_round(0, 0, 0, 0, -1, m);
        cnt++;
      end
      check("eff_period", cnt, per_exp[i]);
      repeat (3) do_round(0, 0, 0, 0, -1, m);
    end

    // Freeze after a pluck: mix holds, then evolution resumes.
    do_round(0, 1, 1, 5, -1, m);
    repeat (2) do_round(0, 0, 0, 0, -1, m);
    do_round(1, 0, 0, 0, -1, m0);
    for (int k = 1; k < 10; k++) begin
      do_round(1, 0, 0, 0, -1, m);
      check("frozen_const", m, m0);
    end
    repeat (5) do_round(0, 0, 0, 0, -1, m);

    // Randomized plucks, periods and freezes.
    for (int k = 0; k < 40; k++) begin
      do_round(($urandom % 6) == 0, ($urandom % 3) == 0, int'($urandom_range(0, NV - 1)),
               int'($urandom_range(0, 127)), -1, m);
    end

    // Reset in the middle of a round: no mix pulse, ring reads silent afterwards.
    @(negedge clk_i);
    prbs_data_i = 2'($urandom); sample_tick_i = 1'b1;
    @(posedge clk_i); #1 sample_tick_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;
    model_reset();
    mv = 0;
    repeat (10) begin
      @(posedge clk_i); #1;
      mv += int'(mix_valid_o);
    end
    check("abort_no_mix", mv, 0);
    check("abort_mix_clr", $signed(mix_o), 0);
    do_round(0, 0, 0, 0, 0, m);
    check("lap_zero", m, 0);
    do_round(0, 1, 3, 6, -1, m);
    repeat (10) do_round(0, 0, 0, 0, -1, m);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
